uart_rx_core: RTL and testbench

Parametrised UART receiver that replaces the fixed 8-bit receive path with configurable data width, parity, and stop bits. It samples with a 3-sample majority vote at each bit centre and rejects false start bits. It reports parity, framing, and overrun errors, and delivers each frame through a one-entry valid/ready holding register. It sits between the asynchronous `data` pin and the consumer logic, and runs from the single system clock.

---
 rtl/uart_rx_core.sv | 116 +++++++++++
 tb/tb_uart_rx_core.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: parametrised UART receiver with majority-vote sampling, parity/framing/overrun reporting and a one-entry valid/ready output
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 busy
);
  localparam int H = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;
  state_t state;
  logic s1, rxs, v0, v1, perr, ferr, dlv;
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic [DATA_BITS-1:0] shift;
  logic vote, wrap, dec;
  assign vote = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
  assign wrap = cnt == CW'(CLKS_PER_BIT - 1);
  assign dec = cnt == CW'(H + 1);
  assign busy = state != S_IDLE;
  // two-flop synchroniser for the asynchronous serial line, idling high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      rxs <= 1'b1;
    end else begin
      s1 <= data;
      rxs <= s1;
    end
  end
  // receive FSM: bit timing, three-point vote, payload shift and pending error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      idx <= '0;
      v0 <= 1'b1;
      v1 <= 1'b1;
      shift <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
      dlv <= 1'b0;
    end else begin
      dlv <= 1'b0;
      if (cnt == CW'(H - 1)) v0 <= rxs;
      if (cnt == CW'(H)) v1 <= rxs;
      cnt <= (state == S_IDLE || state == S_BRK) ? ((state == S_IDLE && !rxs) ? CW'(1) : '0)
                                                 : (wrap ? '0 : cnt + CW'(1));
      case (state)
        S_IDLE: if (!rxs) begin
          state <= S_START;
          perr <= 1'b0;
          ferr <= 1'b0;
        end
        S_START: begin
          if (dec && vote) state <= S_IDLE;
          else if (wrap) begin
            state <= S_DATA;
            idx <= '0;
          end
        end
        S_DATA: begin
          if (dec) shift <= {vote, shift[DATA_BITS-1:1]};
          if (wrap) begin
            idx <= (idx == 4'(DATA_BITS - 1)) ? '0 : idx + 4'd1;
            if (idx == 4'(DATA_BITS - 1)) state <= (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          if (dec) perr <= (^shift ^ vote) != (PARITY == 2);
          if (wrap) state <= S_STOP;
        end
        S_STOP: begin
          if (dec && !vote) ferr <= 1'b1;
          if (dec && idx == 4'(STOP_BITS - 1)) begin
            dlv <= 1'b1;
            state <= (ferr || !vote) ? S_BRK : S_IDLE;
          end
          if (wrap) idx <= idx + 4'd1;
        end
        S_BRK: if (rxs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  // holding register: load on delivery when empty or draining, otherwise flag overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (dlv && (!rx_valid || rx_ready)) begin
        rx_data <= shift;
        parity_err <= perr;
        frame_err <= ferr;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
      overrun <= (dlv && rx_valid && !rx_ready) || (overrun && !err_clr);
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for four receiver configurations (8N1, 8E1, 8O2, 5N1)
module tb_uart_rx_core;
  typedef struct {int i; logic [8:0] d; logic pe; logic fe;} exp_t;
  logic clk, reset;
  logic [3:0] line, rdy, clr, vld, pe, fe, ov, bz;
  logic [7:0] rd0, rd1, rd2;
  logic [4:0] rd3;
  logic [8:0] rd [4];
  int checks = 0, fails = 0;
  int nd_c[4] = '{8, 8, 8, 5};
  int par_c[4] = '{0, 1, 2, 0};
  int st_c[4] = '{1, 1, 2, 1};
  exp_t q[$];
  assign rd[0] = {1'b0, rd0};
  assign rd[1] = {1'b0, rd1};
  assign rd[2] = {1'b0, rd2};
  assign rd[3] = {4'b0, rd3};

  uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .data(line[0]), .rx_data(rd0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .err_clr(clr[0]), .busy(bz[0]));
  uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .data(line[1]), .rx_data(rd1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .err_clr(clr[1]), .busy(bz[1]));
  uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .data(line[2]), .rx_data(rd2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .err_clr(clr[2]), .busy(bz[2]));
  uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u3 (
    .clk(clk), .reset(reset), .data(line[3]), .rx_data(rd3), .rx_valid(vld[3]), .rx_ready(rdy[3]),
    .parity_err(pe[3]), .frame_err(fe[3]), .overrun(ov[3]), .err_clr(clr[3]), .busy(bz[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic v);
    line[i] = v;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [8:0] d, input bit flip, input bit bad_stop, input bit push);
    logic [8:0] m;
    exp_t e;
    m = d & ((9'd1 << nd_c[i]) - 9'd1);
    if (push) begin
      e.i = i; e.d = m; e.pe = flip; e.fe = bad_stop;
      q.push_back(e);
    end
    drive(i, 1'b0);
    for (int b = 0; b < nd_c[i]; b++) drive(i, m[b]);
    if (par_c[i] != 0) drive(i, (^m) ^ (par_c[i] == 2) ^ flip);
    for (int s = 0; s < st_c[i]; s++) drive(i, !(bad_stop && s == st_c[i] - 1));
    line[i] = 1'b1;
  endtask

  // compare every handshake against the oldest expected frame
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++)
      if (vld[i] && rdy[i]) begin
        if (q.size() == 0) chk("unexpected_frame", {28'b0, 4'(i)}, 32'hff);
        else begin
          e = q.pop_front();
          chk("dut_idx", i, e.i);
          chk("rx_data", {23'b0, rd[i]}, {23'b0, e.d});
          chk("parity_err", {31'b0, pe[i]}, {31'b0, e.pe});
          chk("frame_err", {31'b0, fe[i]}, {31'b0, e.fe});
        end
      end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    reset = 1'b0; line = '1; rdy = '1; clr = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", {31'b0, vld[i]}, 0);
      chk("rst_data", {23'b0, rd[i]}, 0);
      chk("rst_flags", {29'b0, pe[i], fe[i], ov[i]}, 0);
      chk("rst_busy", {31'b0, bz[i]}, 0);
    end
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    // 8N1 latency from first low rxs to rx_valid
    n = 0;
    fork
      send(0, 9'hA5, 0, 0, 1);
      begin
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!vld[0] && n < 400);
      end
    join
    chk("latency_edges", n, 157);
    repeat (20) @(posedge clk);
    #1;
    // false start: 5-cycle low pulse
    line[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    line[0] = 1'b1;
    seen = 1'b0;
    repeat (64) begin
      @(posedge clk);
      #1;
      seen |= vld[0];
    end
    chk("false_start_valid", {31'b0, seen}, 0);
    chk("false_start_busy", {31'b0, bz[0]}, 0);
    chk("false_start_flags", {29'b0, pe[0], fe[0], ov[0]}, 0);
    // even and odd parity, second stop bit framing error
    send(1, 9'h3C, 0, 0, 1);
    send(1, 9'h3C, 1, 0, 1);
    send(2, 9'h5A, 0, 0, 1);
    send(2, 9'h5A, 0, 1, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("o2_idle_after_err", {31'b0, bz[2]}, 0);
    // break: 30 bit times low gives exactly one errored frame
    q.push_back('{0, 9'h000, 1'b0, 1'b1});
    line[0] = 1'b0;
    repeat (30 * 16) @(posedge clk);
    #1;
    chk("break_busy", {31'b0, bz[0]}, 1);
    line[0] = 1'b1;
    repeat (48) @(posedge clk);
    #1;
    chk("break_idle", {31'b0, bz[0]}, 0);
    // overrun: second frame dropped while holding register full
    rdy[0] = 1'b0;
    send(0, 9'h11, 0, 0, 1);
    send(0, 9'h22, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("ovr_valid", {31'b0, vld[0]}, 1);
    chk("ovr_data", {23'b0, rd[0]}, 32'h11);
    chk("ovr_flag", {31'b0, ov[0]}, 1);
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    rdy[0] = 1'b0;
    chk("ovr_drain_valid", {31'b0, vld[0]}, 0);
    chk("ovr_sticky", {31'b0, ov[0]}, 1);
    clr[0] = 1'b1;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    chk("ovr_cleared", {31'b0, ov[0]}, 0);
    rdy[0] = 1'b1;
    // 5-bit width, then reset mid-frame
    send(3, 9'h1F, 0, 0, 1);
    repeat (20) @(posedge clk);
    #1;
    drive(3, 1'b0);
    for (int b = 0; b < 4; b++) drive(3, b[0]);
    line[3] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midframe_busy", {31'b0, bz[3]}, 1);
    reset = 1'b0;
    #1;
    chk("arst_data", {23'b0, rd[3]}, 0);
    chk("arst_valid", {31'b0, vld[3]}, 0);
    chk("arst_flags", {29'b0, pe[3], fe[3], ov[3]}, 0);
    chk("arst_busy", {31'b0, bz[3]}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    send(3, 9'h0A, 0, 0, 1);
    repeat (50) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
